// File: rtl/procyon_mdu_pkg.sv
// Shared constants for the procyon multiply/divide unit: funct3 op
// encodings, FSM state type and the op-decode helper.
package procyon_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Datapath control derived from funct3. sel_upper picks the high product
    // half for multiplies and the remainder for divides.
    typedef struct packed {
        logic is_div;
        logic a_signed;
        logic b_signed;
        logic sel_upper;
    } mdu_ctrl_t;

    localparam int FUNCT3_LSB = 12;

    function automatic mdu_ctrl_t mdu_decode(mdu_op_t op);
        mdu_ctrl_t ctrl;
        ctrl = '0;
        case (op)
            MDU_MUL:    ctrl = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, sel_upper: 1'b0};
            MDU_MULH:   ctrl = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, sel_upper: 1'b1};
            MDU_MULHSU: ctrl = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, sel_upper: 1'b1};
            MDU_MULHU:  ctrl = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, sel_upper: 1'b1};
            MDU_DIV:    ctrl = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_upper: 1'b0};
            MDU_DIVU:   ctrl = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_upper: 1'b0};
            MDU_REM:    ctrl = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_upper: 1'b1};
            MDU_REMU:   ctrl = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_upper: 1'b1};
            default:    ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/procyon_mdu_if.sv
// Issue-port and CDB-lane bundle between a reservation station (master)
// and the multiply/divide unit (slave).
interface procyon_mdu_if
    import procyon_mdu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_IDX_WIDTH = 5
);

    logic                     fu_valid;
    logic [DATA_WIDTH-1:0]    fu_insn;
    logic [DATA_WIDTH-1:0]    fu_src_a;
    logic [DATA_WIDTH-1:0]    fu_src_b;
    logic [ROB_IDX_WIDTH-1:0] fu_tag;
    logic                     fu_stall;
    logic                     cdb_en;
    logic [DATA_WIDTH-1:0]    cdb_data;
    logic [ROB_IDX_WIDTH-1:0] cdb_tag;

    modport master (
        output fu_valid, fu_insn, fu_src_a, fu_src_b, fu_tag,
        input  fu_stall, cdb_en, cdb_data, cdb_tag
    );

    modport slave (
        input  fu_valid, fu_insn, fu_src_a, fu_src_b, fu_tag,
        output fu_stall, cdb_en, cdb_data, cdb_tag
    );

endinterface

// File: rtl/procyon_mdu_datapath.sv
// Iterative multiply/divide datapath: shift-add multiply on a 2W
// accumulator, restoring divide on a {remainder, quotient} pair, and the
// final sign fix-up. The result port reflects the value after the current
// step so it can be registered on the last iteration's edge.
module procyon_mdu_datapath
    import procyon_mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  is_div,
    input  logic                  a_signed,
    input  logic                  b_signed,
    input  logic                  sel_upper,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opb_q;
    logic           is_div_q;
    logic           sel_upper_q;
    logic           neg_q;

    logic           sign_a, sign_b, b_zero, neg_start;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_next, div_next, acc_d, prod_fix;
    logic [W-1:0]   div_raw, div_fix;

    // Operand magnitudes and the sign the final result must carry. A zero
    // divisor leaves the all-ones quotient unsigned, and the remainder always
    // follows the dividend, which also makes the overflow case fall out.
    always_comb begin
        sign_a = a_signed & src_a[W-1];
        sign_b = b_signed & src_b[W-1];
        mag_a  = sign_a ? -src_a : src_a;
        mag_b  = sign_b ? -src_b : src_b;
        b_zero = (src_b == '0);
        if (!is_div)        neg_start = sign_a ^ sign_b;
        else if (sel_upper) neg_start = sign_a;
        else                neg_start = (sign_a ^ sign_b) & ~b_zero;
    end

    // One iteration of either algorithm plus the sign-corrected result taken
    // from the post-step value.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
        acc_d     = is_div_q ? div_next : mul_next;
        prod_fix  = neg_q ? -acc_d : acc_d;
        div_raw   = sel_upper_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
        div_fix   = neg_q ? -div_raw : div_raw;
        if (is_div_q)         result = div_fix;
        else if (sel_upper_q) result = prod_fix[2*W-1:W];
        else                  result = prod_fix[W-1:0];
    end

    // Load operands on start, otherwise advance one iteration per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            sel_upper_q <= 1'b0;
            neg_q       <= 1'b0;
        end else if (start) begin
            acc_q       <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            opb_q       <= is_div ? mag_b : mag_a;
            is_div_q    <= is_div;
            sel_upper_q <= sel_upper;
            neg_q       <= neg_start;
        end else if (step) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/procyon_mdu.sv
// Multiply/divide functional unit: issue handshake, IDLE/BUSY sequencing,
// flush handling and the registered CDB broadcast.
module procyon_mdu
    import procyon_mdu_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    input logic           i_flush,
    procyon_mdu_if.slave  bus
);

    localparam int                   CNT_WIDTH = $clog2(OPTN_DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(OPTN_DATA_WIDTH - 1);

    mdu_state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]          count_q;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q;
    logic                          accept, finish, busy;
    mdu_op_t                       op;
    mdu_ctrl_t                     ctrl;
    logic [OPTN_DATA_WIDTH-1:0]    dp_result;
    logic                          insn_unused;

    assign op          = mdu_op_t'(bus.fu_insn[FUNCT3_LSB +: 3]);
    assign ctrl        = mdu_decode(op);
    assign insn_unused = ^{bus.fu_insn[OPTN_DATA_WIDTH-1:FUNCT3_LSB+3], bus.fu_insn[FUNCT3_LSB-1:0]};
    assign busy        = (state_q == MDU_BUSY);
    assign bus.fu_stall = busy;

    // Next-state logic: accept only when idle and not flushing; leave BUSY on
    // flush or after the last iteration, which is also the broadcast edge.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (bus.fu_valid && !i_flush) begin
                    accept  = 1'b1;
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (i_flush) begin
                    state_d = MDU_IDLE;
                end else if (count_q == LAST_ITER) begin
                    finish  = 1'b1;
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State, iteration counter and captured destination tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)    count_q <= '0;
            else if (busy) count_q <= count_q + CNT_WIDTH'(1);
        end
        if (accept) tag_q <= bus.fu_tag;
    end

    // CDB lane: a one-cycle pulse carrying the result of a completed op.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cdb_en   <= 1'b0;
            bus.cdb_data <= '0;
            bus.cdb_tag  <= '0;
        end else begin
            bus.cdb_en <= finish;
            if (finish) begin
                bus.cdb_data <= dp_result;
                bus.cdb_tag  <= tag_q;
            end
        end
    end

    procyon_mdu_datapath #(
        .DATA_WIDTH (OPTN_DATA_WIDTH)
    ) datapath (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .step      (busy),
        .is_div    (ctrl.is_div),
        .a_signed  (ctrl.a_signed),
        .b_signed  (ctrl.b_signed),
        .sel_upper (ctrl.sel_upper),
        .src_a     (bus.fu_src_a),
        .src_b     (bus.fu_src_b),
        .result    (dp_result)
    );

endmodule
